// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_if
//  Description : Request/write-back bundle between a requester and the
//                iterative multiply/divide unit. The requester supplies the
//                operation and operands. The unit returns its status and a
//                register-file write request.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             start;
    logic [1:0]       op;
    logic [AW-1:0]    dst;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             dz;
    logic             write;
    logic [AW-1:0]    wrAddr;
    logic [WIDTH-1:0] wrData;

    modport master (
        output start, op, dst, opA, opB,
        input  busy, done, dz, write, wrAddr, wrData
    );

    modport slave (
        input  start, op, dst, opA, opB,
        output busy, done, dz, write, wrAddr, wrData
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative unsigned multiply / divide unit. It runs one
//                shift-add or restoring shift-subtract step per cycle for
//                WIDTH cycles, then issues a single-cycle register-file
//                write. Supported operations: MULL, MULH, DIV and REM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  wire            clk,
    input  wire            reset,
    mul_div_unit_if.slave  bus
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_dst;
    // Multiplicand for MUL, divisor for DIV/REM
    logic [WIDTH-1:0] r_a;
    // MUL: {hi,lo} is the partial product, with the multiplier shifting out of lo.
    // DIV: hi is the partial remainder, and lo shifts dividend out / quotient in.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_last;
    logic             w_dz;

    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic             r_write;
    logic [AW-1:0]    r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;

    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_cnt == c_last);
    // A zero divisor needs no special datapath handling. Every trial
    // subtraction succeeds, so the quotient becomes all ones and the
    // remainder ends up equal to the dividend.
    assign w_dz     = r_op[1] && (r_a == '0);
    // op[0] selects the high half (MULH) or the remainder (REM).
    assign w_result = r_op[0] ? w_hi_next : w_lo_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_a};
        if (!r_op[1]) begin
            w_hi_next = w_sum[WIDTH:1];
            w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            w_hi_next = w_diff[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_hi_next = w_shift[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture on accept, then one datapath step per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_dst <= '0;
            r_a   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= bus.op;
            r_dst <= bus.dst;
            r_a   <= bus.op[1] ? bus.opB : bus.opA;
            r_hi  <= '0;
            r_lo  <= bus.op[1] ? bus.opA : bus.opB;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
        end
    end

    // Registered outputs. The write request is loaded on the final RUN step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
            r_write   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_write <= 1'b0;
            if ((r_state == S_RUN) && w_last) begin
                r_done    <= 1'b1;
                r_write   <= 1'b1;
                r_dz      <= w_dz;
                r_wr_addr <= r_dst;
                r_wr_data <= w_result;
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.dz     = r_dz;
    assign bus.write  = r_write;
    assign bus.wrAddr = r_wr_addr;
    assign bus.wrData = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_div_unit;

    localparam logic [1:0] c_mull = 2'b00;
    localparam logic [1:0] c_mulh = 2'b01;
    localparam logic [1:0] c_div  = 2'b10;
    localparam logic [1:0] c_rem  = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors   = 0;
    int   checks   = 0;
    int   wr_count = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(16), .AW(3)) bus ();

    mul_div_unit #(.WIDTH(16), .AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count every write pulse seen on a clock edge
    always @(posedge clk) if (bus.write === 1'b1) wr_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] dst,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.dst   = dst;
        bus.opA   = a;
        bus.opB   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    // Advance until write is seen (bounded). lat counts edges since accept.
    task automatic wait_write(inout int lat, inout bit busy_drop);
        while (bus.write !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy !== 1'b1) busy_drop = 1'b1;
        end
    endtask

    task automatic check_wb(input string tag, input int lat, input bit busy_drop,
                            input logic [2:0] dst, input logic [15:0] exp, input logic exp_dz);
        check({tag, " latency"}, lat, 32'd16);
        check({tag, " busy_held"}, {31'd0, busy_drop}, 32'd0);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " wrAddr"}, {29'd0, bus.wrAddr}, {29'd0, dst});
        check({tag, " wrData"}, {16'd0, bus.wrData}, {16'd0, exp});
        check({tag, " dz"}, {31'd0, bus.dz}, {31'd0, exp_dz});
        @(posedge clk);
        #1;
        check({tag, " write_off"}, {31'd0, bus.write}, 32'd0);
        check({tag, " done_off"}, {31'd0, bus.done}, 32'd0);
        check({tag, " dz_off"}, {31'd0, bus.dz}, 32'd0);
        check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] dst,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input logic exp_dz);
        int lat;
        bit bd;
        lat = 0;
        bd  = 1'b0;
        issue(op, dst, a, b);
        wait_write(lat, bd);
        check_wb(tag, lat, bd, dst, exp, exp_dz);
    endtask

    initial begin
        int lat;
        bit bd;
        int wr_before;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.dst   = 3'd0;
        bus.opA   = 16'd0;
        bus.opB   = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst busy",   {31'd0, bus.busy},   32'd0);
        check("rst done",   {31'd0, bus.done},   32'd0);
        check("rst dz",     {31'd0, bus.dz},     32'd0);
        check("rst write",  {31'd0, bus.write},  32'd0);
        check("rst wrAddr", {29'd0, bus.wrAddr}, 32'd0);
        check("rst wrData", {16'd0, bus.wrData}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply
        run_op("mull_300x500", c_mull, 3'd3, 16'h012C, 16'h01F4, 16'h49F0, 1'b0);
        run_op("mulh_300x500", c_mulh, 3'd3, 16'h012C, 16'h01F4, 16'h0002, 1'b0);
        run_op("mulh_ffff",    c_mulh, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("mull_ffff",    c_mull, 3'd1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);

        // Divide / remainder
        run_op("div_1000_7", c_div, 3'd2, 16'd1000, 16'd7, 16'h008E, 1'b0);
        run_op("rem_1000_7", c_rem, 3'd4, 16'd1000, 16'd7, 16'h0006, 1'b0);
        run_op("div_5_9",    c_div, 3'd5, 16'd5,    16'd9, 16'h0000, 1'b0);
        run_op("rem_5_9",    c_rem, 3'd7, 16'd5,    16'd9, 16'h0005, 1'b0);

        // Divide by zero
        run_op("div_by_0", c_div, 3'd0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
        run_op("rem_by_0", c_rem, 3'd6, 16'h1234, 16'h0000, 16'h1234, 1'b1);

        // Start while busy is ignored
        wr_before = wr_count;
        lat = 0;
        bd  = 1'b0;
        issue(c_div, 3'd5, 16'd1000, 16'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = c_mull;
        bus.dst   = 3'd1;
        bus.opA   = 16'd2;
        bus.opB   = 16'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy !== 1'b1) bd = 1'b1;
        end
        bus.start = 1'b0;
        wait_write(lat, bd);
        check_wb("busy_ignore", lat, bd, 3'd5, 16'h008E, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("busy_ignore writes", wr_count - wr_before, 32'd1);
        check("busy_ignore idle", {31'd0, bus.busy}, 32'd0);

        // Reset mid-RUN aborts without a write-back
        wr_before = wr_count;
        issue(c_mull, 3'd7, 16'hFFFF, 16'hFFFF);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = c_mull;
        bus.dst   = 3'd4;
        bus.opA   = 16'd9;
        bus.opB   = 16'd9;
        @(posedge clk);
        #1;
        check("abort busy",   {31'd0, bus.busy},   32'd0);
        check("abort write",  {31'd0, bus.write},  32'd0);
        check("abort wrAddr", {29'd0, bus.wrAddr}, 32'd0);
        check("abort wrData", {16'd0, bus.wrData}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort no_write", wr_count - wr_before, 32'd0);
        check("abort idle", {31'd0, bus.busy}, 32'd0);
        run_op("mull_3x4", c_mull, 3'd2, 16'd3, 16'd4, 16'h000C, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
